axi_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI master write port (AW/W/B) between `NREQ` write requesters, each an AHB-to-AXI write path issuing single-beat writes. Sits between the bridge instances and the system interconnect, and serialises their writes with exactly one write outstanding at a time. It tags each write with the requester index in AWID and routes the B response back to the requester that issued it.

---
 rtl/axi_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//
// Round-robin arbiter that shares one AXI write master port (AW/W/B) between
// NREQ single-beat write requesters. Exactly one write is outstanding at a
// time. Each write carries the requester index in AWID, and the B response is
// routed back to the requester that issued the write.
//
// Optional feature macro: AXI_WR_ARB_TIMEOUT_EN
//   When defined, a B-response timeout of TO_CYCLES cycles moves the FSM to
//   ERR. ERR returns SLVERR to the stalled requester and pulses timeout_o.
//   When undefined, RESP waits indefinitely and timeout_o is tied to 0.
//
// Ports (per-requester vectors pack requester i at slice i):
//   HCLK, HRESET            clock, asynchronous active-high reset
//   req_aw_*                per-requester write address (valid/ready/addr/size)
//   req_w_*                 per-requester write data (valid/ready/data/strb)
//   req_b_*                 per-requester write response (valid/resp/ready)
//   axi_aw_*, axi_w_*       shared AXI master AW and W channels
//   axi_b_*                 shared AXI master B channel
//   timeout_o               one-cycle pulse when a B timeout fires
//   dbg_state_o             current FSM state (IDLE=0, ADDR=1, RESP=2, ERR=3)
//
// Handshake rule for every channel: a beat transfers on a rising HCLK edge
// where valid and ready are both 1. Once this block raises an AXI valid, it
// holds it until the handshake, for as long as the granted requester holds
// its own valid. No ready depends on a valid driven by the same side.
// ---------------------------------------------------------------------------
module axi_wr_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 64,
  parameter int TIDW      = 3,
  parameter int TO_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NREQ-1:0]       req_aw_valid_i,
  output logic [NREQ-1:0]       req_aw_ready_o,
  input  logic [NREQ*AW-1:0]    req_aw_addr_i,
  input  logic [NREQ*3-1:0]     req_aw_size_i,
  input  logic [NREQ-1:0]       req_w_valid_i,
  output logic [NREQ-1:0]       req_w_ready_o,
  input  logic [NREQ*DW-1:0]    req_w_data_i,
  input  logic [NREQ*DW/8-1:0]  req_w_strb_i,
  output logic [NREQ-1:0]       req_b_valid_o,
  output logic [NREQ*2-1:0]     req_b_resp_o,
  input  logic [NREQ-1:0]       req_b_ready_i,
  output logic [TIDW-1:0]       axi_aw_id_o,
  output logic [AW-1:0]         axi_aw_addr_o,
  output logic [7:0]            axi_aw_len_o,
  output logic [2:0]            axi_aw_size_o,
  output logic [1:0]            axi_aw_burst_o,
  output logic                  axi_aw_valid_o,
  input  logic                  axi_aw_ready_i,
  output logic [DW-1:0]         axi_w_data_o,
  output logic [DW/8-1:0]       axi_w_strb_o,
  output logic                  axi_w_last_o,
  output logic                  axi_w_valid_o,
  input  logic                  axi_w_ready_i,
  input  logic [TIDW-1:0]       axi_b_id_i,
  input  logic [1:0]            axi_b_resp_i,
  input  logic                  axi_b_valid_i,
  output logic                  axi_b_ready_o,
  output logic                  timeout_o,
  output logic [1:0]            dbg_state_o
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     rr_ptr_q;
  logic              aw_done_q, w_done_q;

  logic              rr_found;
  logic [GW-1:0]     rr_win;
  logic [GW-1:0]     rr_idx;

  logic              sel_aw_valid, sel_w_valid, sel_b_ready;
  logic [AW-1:0]     sel_addr;
  logic [2:0]        sel_size;
  logic [DW-1:0]     sel_data;
  logic [DW/8-1:0]   sel_strb;

  logic              gr_aw_ready, gr_w_ready, gr_b_valid;
  logic [1:0]        gr_b_resp;

  logic [TIDW-1:0]   grant_id;
  logic              b_match;
  logic              aw_hs, w_hs, aw_all, w_all;
  logic              b_hs_match;
  logic              to_expire;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] v);
    return (v == GW'(NREQ-1)) ? '0 : v + GW'(1);
  endfunction

  assign grant_id    = TIDW'(grant_q);
  assign b_match     = (axi_b_id_i == grant_id);
  assign aw_hs       = axi_aw_valid_o & axi_aw_ready_i;
  assign w_hs        = axi_w_valid_o & axi_w_ready_i;
  // Include the handshake of the current cycle so that ADDR can leave in the
  // same cycle as the second handshake completes.
  assign aw_all      = aw_done_q | aw_hs;
  assign w_all       = w_done_q | w_hs;
  assign b_hs_match  = (state_q == RESP) & axi_b_valid_i & b_match & axi_b_ready_o;
  assign dbg_state_o = state_q;

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_ptr_q;
    rr_idx   = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && req_aw_valid_i[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
      rr_idx = next_idx(rr_idx);
    end
  end

  // Request-side mux from the granted requester.
  always_comb begin
    sel_aw_valid = 1'b0;
    sel_w_valid  = 1'b0;
    sel_b_ready  = 1'b0;
    sel_addr     = '0;
    sel_size     = '0;
    sel_data     = '0;
    sel_strb     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_aw_valid = req_aw_valid_i[i];
        sel_w_valid  = req_w_valid_i[i];
        sel_b_ready  = req_b_ready_i[i];
        sel_addr     = req_aw_addr_i[i*AW +: AW];
        sel_size     = req_aw_size_i[i*3 +: 3];
        sel_data     = req_w_data_i[i*DW +: DW];
        sel_strb     = req_w_strb_i[i*(DW/8) +: (DW/8)];
      end
    end
  end

  assign axi_aw_id_o    = grant_id;
  assign axi_aw_addr_o  = sel_addr;
  assign axi_aw_size_o  = sel_size;
  assign axi_aw_len_o   = 8'd0;
  assign axi_aw_burst_o = 2'b01;
  assign axi_w_data_o   = sel_data;
  assign axi_w_strb_o   = sel_strb;
  assign axi_w_last_o   = 1'b1;

  // FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rr_found) state_d = ADDR;
      ADDR: if (aw_all && w_all) state_d = RESP;
      RESP: begin
        if (b_hs_match)     state_d = IDLE;
        else if (to_expire) state_d = ERR;
      end
`ifdef AXI_WR_ARB_TIMEOUT_EN
      ERR:  if (sel_b_ready) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and per-requester demux. Non-granted bits stay 0.
  always_comb begin
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    gr_aw_ready    = 1'b0;
    gr_w_ready     = 1'b0;
    gr_b_valid     = 1'b0;
    gr_b_resp      = 2'b00;
    case (state_q)
      ADDR: begin
        axi_aw_valid_o = sel_aw_valid & ~aw_done_q;
        axi_w_valid_o  = sel_w_valid & ~w_done_q;
        gr_aw_ready    = axi_aw_ready_i & ~aw_done_q;
        gr_w_ready     = axi_w_ready_i & ~w_done_q;
      end
      RESP: begin
        // A B beat carrying another ID is a stray; sink it unconditionally.
        axi_b_ready_o = b_match ? sel_b_ready : 1'b1;
        gr_b_valid    = axi_b_valid_i & b_match;
        gr_b_resp     = axi_b_resp_i;
      end
`ifdef AXI_WR_ARB_TIMEOUT_EN
      ERR: begin
        // A late B for the timed-out write may arrive here; drop it.
        axi_b_ready_o = 1'b1;
        gr_b_valid    = 1'b1;
        gr_b_resp     = 2'b10;
      end
`endif
      default: ;
    endcase

    req_aw_ready_o = '0;
    req_w_ready_o  = '0;
    req_b_valid_o  = '0;
    req_b_resp_o   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        req_aw_ready_o[i]      = gr_aw_ready;
        req_w_ready_o[i]       = gr_w_ready;
        req_b_valid_o[i]       = gr_b_valid;
        req_b_resp_o[i*2 +: 2] = gr_b_resp;
      end
    end
  end

  // Grant, round-robin pointer and AW/W completion flags.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && rr_found) grant_q <= rr_win;
      if (state_q == ADDR) begin
        if (aw_all && w_all) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_all;
          w_done_q  <= w_all;
        end
      end
      if (b_hs_match) rr_ptr_q <= next_idx(grant_q);
`ifdef AXI_WR_ARB_TIMEOUT_EN
      if (state_q == ERR && sel_b_ready) rr_ptr_q <= next_idx(grant_q);
`endif
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int TCW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  logic [TCW-1:0] to_cnt_q;

  // Counter is 0 in the first RESP cycle, so expiry lands on RESP cycle
  // TO_CYCLES unless the matching B completes in that same cycle.
  assign to_expire = (state_q == RESP) && (to_cnt_q == TCW'(TO_CYCLES-1)) && !b_hs_match;
  assign timeout_o = to_expire;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                to_cnt_q <= '0;
    else if (state_q != RESP)  to_cnt_q <= '0;
    else                       to_cnt_q <= to_cnt_q + TCW'(1);
  end
`else
  assign to_expire = 1'b0;
  // Constant 0 for any legal TO_CYCLES; RESP waits indefinitely in this build.
  assign timeout_o = (TO_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int TIDW = 3;
  localparam int TOC  = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic                  HCLK;
  logic                  HRESET;
  logic [NREQ-1:0]       req_aw_valid_i;
  logic [NREQ-1:0]       req_aw_ready_o;
  logic [NREQ*AW-1:0]    req_aw_addr_i;
  logic [NREQ*3-1:0]     req_aw_size_i;
  logic [NREQ-1:0]       req_w_valid_i;
  logic [NREQ-1:0]       req_w_ready_o;
  logic [NREQ*DW-1:0]    req_w_data_i;
  logic [NREQ*DW/8-1:0]  req_w_strb_i;
  logic [NREQ-1:0]       req_b_valid_o;
  logic [NREQ*2-1:0]     req_b_resp_o;
  logic [NREQ-1:0]       req_b_ready_i;
  logic [TIDW-1:0]       axi_aw_id_o;
  logic [AW-1:0]         axi_aw_addr_o;
  logic [7:0]            axi_aw_len_o;
  logic [2:0]            axi_aw_size_o;
  logic [1:0]            axi_aw_burst_o;
  logic                  axi_aw_valid_o;
  logic                  axi_aw_ready_i;
  logic [DW-1:0]         axi_w_data_o;
  logic [DW/8-1:0]       axi_w_strb_o;
  logic                  axi_w_last_o;
  logic                  axi_w_valid_o;
  logic                  axi_w_ready_i;
  logic [TIDW-1:0]       axi_b_id_i;
  logic [1:0]            axi_b_resp_i;
  logic                  axi_b_valid_i;
  logic                  axi_b_ready_o;
  logic                  timeout_o;
  logic [1:0]            dbg_state_o;

  axi_wr_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIDW(TIDW), .TO_CYCLES(TOC)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o),
    .req_aw_addr_i(req_aw_addr_i), .req_aw_size_i(req_aw_size_i),
    .req_w_valid_i(req_w_valid_i), .req_w_ready_o(req_w_ready_o),
    .req_w_data_i(req_w_data_i), .req_w_strb_i(req_w_strb_i),
    .req_b_valid_o(req_b_valid_o), .req_b_resp_o(req_b_resp_o),
    .req_b_ready_i(req_b_ready_i),
    .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o),
    .axi_aw_len_o(axi_aw_len_o), .axi_aw_size_o(axi_aw_size_o),
    .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_valid_o(axi_aw_valid_o),
    .axi_aw_ready_i(axi_aw_ready_i),
    .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
    .axi_w_last_o(axi_w_last_o), .axi_w_valid_o(axi_w_valid_o),
    .axi_w_ready_i(axi_w_ready_i),
    .axi_b_id_i(axi_b_id_i), .axi_b_resp_i(axi_b_resp_i),
    .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
    .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int aw_cnt   = 0;
  int w_cnt    = 0;
  logic [TIDW-1:0] exp_q[$];
  logic [AW-1:0]   addr_tab[NREQ];
  logic [DW-1:0]   data_tab[NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // AW handshakes are compared in order against the expected issuer IDs.
  always @(negedge HCLK) begin
    if (!HRESET && axi_aw_valid_o && axi_aw_ready_i) begin
      aw_cnt++;
      if (exp_q.size() == 0) check("aw_sb_size", exp_q.size(), 1);
      else                   check("aw_sb_id", axi_aw_id_o, exp_q.pop_front());
    end
    if (!HRESET && axi_w_valid_o && axi_w_ready_i) w_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic v);
    req_aw_valid_i[r] = v;
    req_w_valid_i[r]  = v;
  endtask

  // Full zero-wait transaction. Called just after a rising edge with the DUT
  // in IDLE and the winning requester's valids raised; returns just after the
  // edge that completes the B handshake.
  task automatic run_txn(input int id, input logic [1:0] resp);
    logic [NREQ-1:0]   oh;
    logic [2*NREQ-1:0] rs;
    oh = '0;
    oh[id] = 1'b1;
    rs = '0;
    rs[2*id +: 2] = resp;
    exp_q.push_back(TIDW'(id));
    @(negedge HCLK);
    check("txn_idle", dbg_state_o, S_IDLE);
    check("txn_awv_idle", axi_aw_valid_o, 0);
    tick();
    @(negedge HCLK);
    check("txn_addr", dbg_state_o, S_ADDR);
    check("txn_aw_id", axi_aw_id_o, id);
    check("txn_aw_addr", axi_aw_addr_o, addr_tab[id]);
    check("txn_len_burst", {axi_aw_len_o, axi_aw_burst_o}, {8'd0, 2'b01});
    check("txn_w_data", axi_w_data_o, data_tab[id]);
    check("txn_w_last", axi_w_last_o, 1);
    check("txn_aw_w_valid", {axi_aw_valid_o, axi_w_valid_o}, 2'b11);
    check("txn_req_ready", {req_aw_ready_o, req_w_ready_o}, {oh, oh});
    tick();
    axi_b_valid_i = 1'b1;
    axi_b_id_i    = TIDW'(id);
    axi_b_resp_i  = resp;
    @(negedge HCLK);
    check("txn_resp", dbg_state_o, S_RESP);
    check("txn_awv_resp", axi_aw_valid_o, 0);
    check("txn_b_valid", req_b_valid_o, oh);
    check("txn_b_resp", req_b_resp_o, rs);
    check("txn_b_ready", axi_b_ready_o, 1);
    tick();
    axi_b_valid_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int aw0, w0;

  initial begin
    HRESET         = 1'b1;
    req_aw_valid_i = '0;
    req_w_valid_i  = '0;
    req_b_ready_i  = 2'b11;
    addr_tab[0]    = 32'h0000_1000;
    addr_tab[1]    = 32'h0000_2000;
    data_tab[0]    = 64'h0000_0000_0000_00A5;
    data_tab[1]    = 64'h1234_5678_9ABC_5A5A;
    req_aw_addr_i  = {32'h0000_2000, 32'h0000_1000};
    req_w_data_i   = {64'h1234_5678_9ABC_5A5A, 64'h0000_0000_0000_00A5};
    req_aw_size_i  = {3'd3, 3'd3};
    req_w_strb_i   = '1;
    axi_aw_ready_i = 1'b1;
    axi_w_ready_i  = 1'b1;
    axi_b_valid_i  = 1'b0;
    axi_b_id_i     = '0;
    axi_b_resp_i   = 2'b00;

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_state", dbg_state_o, S_IDLE);
    check("rst_valids", {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o}, 0);
    check("rst_req_ready", {req_aw_ready_o, req_w_ready_o, req_b_valid_o}, 0);
    check("rst_timeout", timeout_o, 0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Single write from requester 0, then one from requester 1
    set_req(0, 1'b1);
    run_txn(0, 2'b00);
    set_req(0, 1'b0);
    check("single_aw_cnt", aw_cnt, 1);
    check("single_w_cnt", w_cnt, 1);
    set_req(1, 1'b1);
    run_txn(1, 2'b01);
    set_req(1, 1'b0);

    // Contention: both request continuously -> 0,1,0,1
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    for (int k = 0; k < 4; k++) run_txn(k % 2, (k == 2) ? 2'b10 : 2'b00);
    set_req(0, 1'b0);
    set_req(1, 1'b0);

    // AW/W skew: W ready held low for 5 cycles after the AW handshake
    aw0 = aw_cnt;
    w0  = w_cnt;
    exp_q.push_back(0);
    axi_w_ready_i = 1'b0;
    set_req(0, 1'b1);
    tick();
    @(negedge HCLK);
    check("skew_addr", dbg_state_o, S_ADDR);
    check("skew_awv", axi_aw_valid_o, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge HCLK);
      check("skew_aw_held", axi_aw_valid_o, 0);
      check("skew_aw_ready", req_aw_ready_o, 0);
      check("skew_w_valid", axi_w_valid_o, 1);
      check("skew_state", dbg_state_o, S_ADDR);
      tick();
    end
    axi_w_ready_i = 1'b1;
    @(negedge HCLK);
    check("skew_w_ready", req_w_ready_o, 2'b01);
    tick();
    set_req(0, 1'b0);
    @(negedge HCLK);
    check("skew_resp", dbg_state_o, S_RESP);
    check("skew_one_aw", aw_cnt - aw0, 1);
    check("skew_one_w", w_cnt - w0, 1);
    axi_b_valid_i = 1'b1;
    axi_b_id_i    = 3'd0;
    axi_b_resp_i  = 2'b00;
    tick();
    axi_b_valid_i = 1'b0;

    // Response backpressure on requester 1 with requester 0 waiting
    exp_q.push_back(1);
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    req_b_ready_i = 2'b01;
    tick();
    @(negedge HCLK);
    check("bp_grant", axi_aw_id_o, 1);
    tick();
    set_req(1, 1'b0);
    axi_b_valid_i = 1'b1;
    axi_b_id_i    = 3'd5;
    axi_b_resp_i  = 2'b00;
    @(negedge HCLK);
    check("stray_b_ready", axi_b_ready_o, 1);
    check("stray_no_route", req_b_valid_o, 0);
    tick();
    axi_b_id_i = 3'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      check("bp_b_ready", axi_b_ready_o, 0);
      check("bp_b_valid", req_b_valid_o, 2'b10);
      check("bp_state", dbg_state_o, S_RESP);
      check("bp_no_aw", axi_aw_valid_o, 0);
      tick();
    end
    req_b_ready_i = 2'b11;
    @(negedge HCLK);
    check("bp_release", axi_b_ready_o, 1);
    tick();
    axi_b_valid_i = 1'b0;
    run_txn(0, 2'b00);
    set_req(0, 1'b0);

    // Reset while in RESP
    exp_q.push_back(1);
    set_req(1, 1'b1);
    req_b_ready_i = 2'b00;
    tick();
    tick();
    axi_b_valid_i = 1'b1;
    axi_b_id_i    = 3'd1;
    axi_b_resp_i  = 2'b00;
    @(negedge HCLK);
    check("mid_b_valid", req_b_valid_o, 2'b10);
    #2 HRESET = 1'b1;
    #1;
    check("mid_rst_state", dbg_state_o, S_IDLE);
    check("mid_rst_axi", {axi_aw_valid_o, axi_w_valid_o, axi_b_ready_o}, 0);
    check("mid_rst_req", {req_aw_ready_o, req_w_ready_o, req_b_valid_o}, 0);
    axi_b_valid_i = 1'b0;
    req_b_ready_i = 2'b11;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    run_txn(0, 2'b00);
    set_req(0, 1'b0);
    run_txn(1, 2'b00);
    set_req(1, 1'b0);

`ifdef AXI_WR_ARB_TIMEOUT_EN
    // Timeout: slave never answers; SLVERR returned, late B dropped
    exp_q.push_back(0);
    set_req(0, 1'b1);
    req_b_ready_i = 2'b00;
    tick();
    tick();
    set_req(0, 1'b0);
    for (int c = 1; c <= TOC; c++) begin
      @(negedge HCLK);
      check("to_pulse", timeout_o, (c == TOC));
      tick();
    end
    axi_b_valid_i = 1'b1;
    axi_b_id_i    = 3'd0;
    axi_b_resp_i  = 2'b00;
    @(negedge HCLK);
    check("to_err_state", dbg_state_o, S_ERR);
    check("to_err_valid", req_b_valid_o, 2'b01);
    check("to_err_resp", req_b_resp_o, 4'b0010);
    check("to_late_b_drop", axi_b_ready_o, 1);
    check("to_pulse_end", timeout_o, 0);
    req_b_ready_i = 2'b01;
    tick();
    axi_b_valid_i = 1'b0;
    req_b_ready_i = 2'b11;
    @(negedge HCLK);
    check("to_back_idle", dbg_state_o, S_IDLE);
`else
    @(negedge HCLK);
    check("no_to_timeout", timeout_o, 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
